// File: rtl/interfaz_de_salida_param.sv
`default_nettype none
// ============================================================================
//  Module   : interfaz_de_salida_param
//  Purpose  : Output interface of an elevator controller. It keeps the button
//             lamps, the floor display and the direction display. Every
//             output is a register, so each output follows its inputs with
//             one clock of latency.
//
//  Parameters
//    PISOS    - number of served floors (2..16)
//    WP       - floor-number width, 2**WP >= PISOS
//    PARPADEO - half-period of the door blink, in clk cycles (2..255)
//    NB       - (local) button count = 3*PISOS-2
//               (PISOS cabin, PISOS-1 up, PISOS-1 down)
//
//  Ports
//    clk            in   single clock, rising edge
//    rst_n          in   synchronous reset, active low
//    solicitudes    in   [NB] one-cycle press pulses, one per button
//    atendidos      in   [NB] one-cycle served pulses, one per button
//    piso           in   [WP] current car floor
//    subiendo       in   car moving up
//    bajando        in   car moving down
//    puerta_abierta in   door open
//    luces          out  [NB] button lamps
//    display_num    out  [WP] floor shown
//    display_dir    out  [2]  00 idle, 10 up, 11 down, 01 door / pending
//    err_piso       out  piso was out of range in the previous cycle
//
//  Build option
//    INTERFAZ_PARPADEO_EN - when defined, the door code blinks between 00
//                           and 01 with a half-period of PARPADEO cycles.
//                           When undefined, the door code is a steady 01.
//
//  Revision : 1.0 - initial release
// ============================================================================
module interfaz_de_salida_param #(
    parameter int PISOS    = 4,
    parameter int WP       = 2,
    parameter int PARPADEO = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3*PISOS-3:0]   solicitudes,
    input  logic [3*PISOS-3:0]   atendidos,
    input  logic [WP-1:0]        piso,
    input  logic                 subiendo,
    input  logic                 bajando,
    input  logic                 puerta_abierta,
    output logic [3*PISOS-3:0]   luces,
    output logic [WP-1:0]        display_num,
    output logic [1:0]           display_dir,
    output logic                 err_piso
);

    localparam int NB = 3*PISOS-2;

    // Display codes, one per direction state.
    localparam logic [1:0] c_DIR_IDLE = 2'b00;
    localparam logic [1:0] c_DIR_UP   = 2'b10;
    localparam logic [1:0] c_DIR_DOWN = 2'b11;
    localparam logic [1:0] c_DIR_DOOR = 2'b01;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter guards
    // ------------------------------------------------------------------------
    if (PISOS < 2 || PISOS > 16) begin : g_bad_pisos
        $error("interfaz_de_salida_param: PISOS must be in 2..16");
    end
    if ((1 << WP) < PISOS) begin : g_bad_wp
        $error("interfaz_de_salida_param: 2**WP must be >= PISOS");
    end
    if (PARPADEO < 2 || PARPADEO > 255) begin : g_bad_parpadeo
        $error("interfaz_de_salida_param: PARPADEO must be in 2..255");
    end

    // ------------------------------------------------------------------------
    // Direction state machine encoding. The state code equals the display
    // code so the display is a direct copy except for the special cases.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        REPOSO = 2'b00,
        SUBE   = 2'b10,
        BAJA   = 2'b11,
        PUERTA = 2'b01
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [NB-1:0]     r_luces;
    logic [NB-1:0]     w_luces_next;
    logic              w_luces_any;

    logic [WP-1:0]     r_display_num;
    logic [1:0]        r_display_dir;
    logic [1:0]        w_display_dir_next;
    logic              r_err_piso;
    logic              w_piso_ok;

    // ------------------------------------------------------------------------
    // Button lamps: a press sets the lamp, a served pulse clears it, and a
    // press arriving together with a served pulse keeps the lamp on.
    // ------------------------------------------------------------------------
    assign w_luces_next = (r_luces & ~atendidos) | solicitudes;
    assign w_luces_any  = |w_luces_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_luces <= '0;
        end else begin
            r_luces <= w_luces_next;
        end
    end

    // ------------------------------------------------------------------------
    // Floor range check. When every code of piso is a legal floor the check
    // collapses to a constant, which avoids a comparison that can never fail.
    // ------------------------------------------------------------------------
    if ((1 << WP) == PISOS) begin : g_piso_full_range
        assign w_piso_ok = 1'b1;
    end else begin : g_piso_partial_range
        localparam logic [WP:0] c_PISOS_LIM = PISOS[WP:0];
        assign w_piso_ok = ({1'b0, piso} < c_PISOS_LIM);
    end

    // The display holds its last legal floor; err_piso is recomputed every
    // cycle, so it only stays high while piso keeps being out of range.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_display_num <= '0;
            r_err_piso    <= 1'b0;
        end else begin
            if (w_piso_ok) begin
                r_display_num <= piso;
            end
            r_err_piso <= ~w_piso_ok;
        end
    end

    // ------------------------------------------------------------------------
    // Direction FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= REPOSO;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Direction FSM: next state. The door has the highest priority; a
    // contradictory up+down indication keeps whatever was shown before.
    // With no motion, a trip in progress is kept while lamps are still lit.
    // The lamp test uses the lamp value being registered this cycle so the
    // display and the lamps change together.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (puerta_abierta) begin
            w_state_next = PUERTA;
        end else if (subiendo && !bajando) begin
            w_state_next = SUBE;
        end else if (bajando && !subiendo) begin
            w_state_next = BAJA;
        end else if (subiendo && bajando) begin
            w_state_next = r_state;
        end else if ((r_state == SUBE || r_state == BAJA) && w_luces_any) begin
            w_state_next = r_state;
        end else begin
            w_state_next = REPOSO;
        end
    end

`ifdef INTERFAZ_PARPADEO_EN
    // ------------------------------------------------------------------------
    // Door blink. The counter only advances while the FSM stays in PUERTA;
    // entering or leaving PUERTA restarts it with the phase low, so every
    // door opening begins with a full "off" half-period.
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_BLINK_LAST = 8'(PARPADEO - 1);

    logic [7:0] r_blink_cnt;
    logic [7:0] w_blink_cnt_next;
    logic       r_phase;
    logic       w_phase_next;

    always_comb begin
        w_blink_cnt_next = 8'd0;
        w_phase_next     = 1'b0;
        if (r_state == PUERTA && w_state_next == PUERTA) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                w_blink_cnt_next = 8'd0;
                w_phase_next     = ~r_phase;
            end else begin
                w_blink_cnt_next = r_blink_cnt + 8'd1;
                w_phase_next     = r_phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_next;
            r_phase     <= w_phase_next;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Direction display, computed from the next state so that it is a plain
    // register on the output. An idle car with lit lamps shows the door code
    // to signal pending requests.
    // ------------------------------------------------------------------------
    always_comb begin
        w_display_dir_next = c_DIR_IDLE;
        case (w_state_next)
            REPOSO:  w_display_dir_next = w_luces_any ? c_DIR_DOOR : c_DIR_IDLE;
            SUBE:    w_display_dir_next = c_DIR_UP;
            BAJA:    w_display_dir_next = c_DIR_DOWN;
`ifdef INTERFAZ_PARPADEO_EN
            PUERTA:  w_display_dir_next = {1'b0, w_phase_next};
`else
            PUERTA:  w_display_dir_next = c_DIR_DOOR;
`endif
            default: w_display_dir_next = c_DIR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_display_dir <= c_DIR_IDLE;
        end else begin
            r_display_dir <= w_display_dir_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign luces       = r_luces;
    assign display_num = r_display_num;
    assign display_dir = r_display_dir;
    assign err_piso    = r_err_piso;

endmodule
`default_nettype wire

// File: tb/tb_interfaz_de_salida_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interfaz_de_salida_param
//  Purpose  : Self-checking bench for interfaz_de_salida_param. A default
//             instance (PISOS=4, WP=2, PARPADEO=4) runs a vector table plus
//             door/reset sequences; a second instance (PISOS=5, WP=3)
//             exercises the out-of-range floor handling.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_interfaz_de_salida_param;

    // First door code after entering PUERTA: blink starts with phase low.
`ifdef INTERFAZ_PARPADEO_EN
    localparam logic [1:0] DOOR0 = 2'b00;
`else
    localparam logic [1:0] DOOR0 = 2'b01;
`endif

    logic       clk;
    logic       rst_n;
    logic [9:0] sol;
    logic [9:0] ate;
    logic [1:0] piso;
    logic       sub;
    logic       baj;
    logic       door;
    logic [9:0] luces;
    logic [1:0] dnum;
    logic [1:0] ddir;
    logic       err;

    logic        rst5_n;
    logic [12:0] sol5;
    logic [12:0] ate5;
    logic [2:0]  piso5;
    logic        sub5;
    logic        baj5;
    logic        door5;
    logic [12:0] luces5;
    logic [2:0]  dnum5;
    logic [1:0]  ddir5;
    logic        err5;

    int n_tests = 0;
    int n_fail  = 0;

    interfaz_de_salida_param #(.PISOS(4), .WP(2), .PARPADEO(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .solicitudes    (sol),
        .atendidos      (ate),
        .piso           (piso),
        .subiendo       (sub),
        .bajando        (baj),
        .puerta_abierta (door),
        .luces          (luces),
        .display_num    (dnum),
        .display_dir    (ddir),
        .err_piso       (err)
    );

    interfaz_de_salida_param #(.PISOS(5), .WP(3), .PARPADEO(4)) dut5 (
        .clk            (clk),
        .rst_n          (rst5_n),
        .solicitudes    (sol5),
        .atendidos      (ate5),
        .piso           (piso5),
        .subiendo       (sub5),
        .bajando        (baj5),
        .puerta_abierta (door5),
        .luces          (luces5),
        .display_num    (dnum5),
        .display_dir    (ddir5),
        .err_piso       (err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [9:0] sol;
        logic [9:0] ate;
        logic [1:0] piso;
        logic       sub;
        logic       baj;
        logic       door;
        logic [9:0] e_luces;
        logic [1:0] e_num;
        logic [1:0] e_dir;
        logic       e_err;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string nm, input logic [9:0] el, input logic [1:0] en,
                              input logic [1:0] ed, input logic ee);
        check({nm, ".luces"}, 32'(luces), 32'(el));
        check({nm, ".num"},   32'(dnum),  32'(en));
        check({nm, ".dir"},   32'(ddir),  32'(ed));
        check({nm, ".err"},   32'(err),   32'(ee));
    endtask

    task automatic drive(input logic r, input logic [9:0] s, input logic [9:0] a,
                         input logic [1:0] p, input logic su, input logic ba, input logic d);
        rst_n = r; sol = s; ate = a; piso = p; sub = su; baj = ba; door = d;
    endtask

    initial begin
        //            rst  sol      ate      piso  sub  baj  door   luces    num   dir    err
        vecs[0]  = '{1'b0, 10'h000, 10'h000, 2'd0, 1'b0,1'b0,1'b0, 10'h000, 2'd0, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 10'h000, 10'h000, 2'd0, 1'b0,1'b0,1'b0, 10'h000, 2'd0, 2'b00, 1'b0};
        vecs[2]  = '{1'b1, 10'h004, 10'h000, 2'd0, 1'b0,1'b0,1'b0, 10'h004, 2'd0, 2'b01, 1'b0};
        vecs[3]  = '{1'b1, 10'h000, 10'h000, 2'd0, 1'b0,1'b0,1'b0, 10'h004, 2'd0, 2'b01, 1'b0};
        vecs[4]  = '{1'b1, 10'h000, 10'h004, 2'd0, 1'b0,1'b0,1'b0, 10'h000, 2'd0, 2'b00, 1'b0};
        vecs[5]  = '{1'b1, 10'h010, 10'h010, 2'd0, 1'b0,1'b0,1'b0, 10'h010, 2'd0, 2'b01, 1'b0};
        vecs[6]  = '{1'b1, 10'h000, 10'h000, 2'd2, 1'b0,1'b0,1'b0, 10'h010, 2'd2, 2'b01, 1'b0};
        vecs[7]  = '{1'b1, 10'h000, 10'h000, 2'd3, 1'b1,1'b0,1'b0, 10'h010, 2'd3, 2'b10, 1'b0};
        vecs[8]  = '{1'b1, 10'h000, 10'h000, 2'd3, 1'b0,1'b0,1'b0, 10'h010, 2'd3, 2'b10, 1'b0};
        vecs[9]  = '{1'b1, 10'h000, 10'h010, 2'd3, 1'b0,1'b0,1'b0, 10'h000, 2'd3, 2'b00, 1'b0};
        vecs[10] = '{1'b1, 10'h000, 10'h000, 2'd2, 1'b0,1'b1,1'b0, 10'h000, 2'd2, 2'b11, 1'b0};
        vecs[11] = '{1'b1, 10'h000, 10'h000, 2'd2, 1'b0,1'b0,1'b0, 10'h000, 2'd2, 2'b00, 1'b0};
        vecs[12] = '{1'b1, 10'h001, 10'h000, 2'd1, 1'b1,1'b1,1'b0, 10'h001, 2'd1, 2'b01, 1'b0};
        vecs[13] = '{1'b1, 10'h000, 10'h000, 2'd1, 1'b1,1'b0,1'b0, 10'h001, 2'd1, 2'b10, 1'b0};
        vecs[14] = '{1'b1, 10'h000, 10'h000, 2'd1, 1'b1,1'b1,1'b0, 10'h001, 2'd1, 2'b10, 1'b0};
        vecs[15] = '{1'b1, 10'h000, 10'h000, 2'd1, 1'b0,1'b1,1'b0, 10'h001, 2'd1, 2'b11, 1'b0};
        vecs[16] = '{1'b1, 10'h000, 10'h000, 2'd1, 1'b0,1'b1,1'b1, 10'h001, 2'd1, DOOR0, 1'b0};
        vecs[17] = '{1'b1, 10'h000, 10'h000, 2'd1, 1'b1,1'b0,1'b1, 10'h001, 2'd1, DOOR0, 1'b0};
        vecs[18] = '{1'b1, 10'h000, 10'h000, 2'd1, 1'b0,1'b0,1'b0, 10'h001, 2'd1, 2'b01, 1'b0};
        vecs[19] = '{1'b1, 10'h000, 10'h000, 2'd1, 1'b0,1'b0,1'b1, 10'h001, 2'd1, DOOR0, 1'b0};
        vecs[20] = '{1'b1, 10'h000, 10'h000, 2'd1, 1'b0,1'b1,1'b0, 10'h001, 2'd1, 2'b11, 1'b0};
        vecs[21] = '{1'b1, 10'h3FF, 10'h000, 2'd1, 1'b0,1'b0,1'b1, 10'h3FF, 2'd1, DOOR0, 1'b0};
        vecs[22] = '{1'b0, 10'h3FF, 10'h000, 2'd1, 1'b0,1'b0,1'b1, 10'h000, 2'd0, 2'b00, 1'b0};
        vecs[23] = '{1'b1, 10'h000, 10'h000, 2'd0, 1'b0,1'b0,1'b0, 10'h000, 2'd0, 2'b00, 1'b0};

        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst5_n = 1'b0; sol5 = '0; ate5 = '0; piso5 = '0; sub5 = 1'b0; baj5 = 1'b0; door5 = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].sol, vecs[i].ate, vecs[i].piso,
                  vecs[i].sub, vecs[i].baj, vecs[i].door);
            tick();
            check_main($sformatf("vec%0d", i), vecs[i].e_luces, vecs[i].e_num,
                       vecs[i].e_dir, vecs[i].e_err);
        end

        // ---------------- door held 20 cycles ----------------
        drive(1'b1, '0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
`ifdef INTERFAZ_PARPADEO_EN
            check($sformatf("blink%0d", i), 32'(ddir), ((i / 4) % 2 == 1) ? 32'd1 : 32'd0);
`else
            check($sformatf("door_steady%0d", i), 32'(ddir), 32'd1);
`endif
        end
        drive(1'b1, '0, '0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check("door_exit_up", 32'(ddir), 32'b10);

        // ---------------- reset in the middle of a blink ----------------
        drive(1'b1, 10'h3FF, '0, 2'd2, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, '0, '0, 2'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("midblink_luces_full", 32'(luces), 32'h3FF);
        drive(1'b0, 10'h3FF, 10'h000, 2'd2, 1'b0, 1'b0, 1'b1);
        tick();
        check_main("midblink_rst", 10'h000, 2'd0, 2'b00, 1'b0);

        // Door after reset and after a short close: the blink restarts low.
        drive(1'b1, '0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef INTERFAZ_PARPADEO_EN
            check($sformatf("post_rst_blink%0d", i), 32'(ddir), (i >= 4) ? 32'd1 : 32'd0);
`else
            check($sformatf("post_rst_door%0d", i), 32'(ddir), 32'd1);
`endif
        end
        drive(1'b1, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("door_closed_idle", 32'(ddir), 32'b00);
        drive(1'b1, '0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check("door_reopen", 32'(ddir), 32'(DOOR0));

        // ---------------- out-of-range floor, PISOS=5 ----------------
        tick();
        check("p5_rst.num", 32'(dnum5), 32'd0);
        check("p5_rst.err", 32'(err5),  32'd0);
        rst5_n = 1'b1; piso5 = 3'd3;
        tick();
        check("p5_3.num", 32'(dnum5), 32'd3);
        check("p5_3.err", 32'(err5),  32'd0);
        piso5 = 3'd6;
        tick();
        check("p5_6.num", 32'(dnum5), 32'd3);
        check("p5_6.err", 32'(err5),  32'd1);
        piso5 = 3'd4;
        tick();
        check("p5_4.num", 32'(dnum5), 32'd4);
        check("p5_4.err", 32'(err5),  32'd0);
        piso5 = 3'd5;
        tick();
        check("p5_5.num", 32'(dnum5), 32'd4);
        check("p5_5.err", 32'(err5),  32'd1);
        piso5 = 3'd0;
        tick();
        check("p5_0.num", 32'(dnum5), 32'd0);
        check("p5_0.err", 32'(err5),  32'd0);
        check("p5_luces", 32'(luces5), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interfaz_de_salida_param.md
INTERFAZ_DE_SALIDA_PARAM -- requirements
Module: interfaz_de_salida_param

Interface
REQ-001 The block SHALL have parameter PISOS, default 4, meaning number of served floors (legal 2..16).
REQ-002 The block SHALL have parameter WP, default 2, meaning floor-number width, with 2**WP >= PISOS.
REQ-003 The block SHALL have parameter PARPADEO, default 8, meaning half-period in clk cycles of the door blink (legal 2..255).
REQ-004 The block SHALL have localparam NB = 3*PISOS-2 (default 10), meaning button count: PISOS cabin buttons, PISOS-1 up, PISOS-1 down.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning reset; synchronous and active-low.
REQ-007 The block SHALL have port solicitudes, input, NB, meaning one-cycle press pulses per button.
REQ-008 The block SHALL have port atendidos, input, NB, meaning one-cycle served pulses per button.
REQ-009 The block SHALL have port piso, input, WP, meaning current car floor.
REQ-010 The block SHALL have ports subiendo and bajando, input, 1 each, meaning car moving up / down.
REQ-011 The block SHALL have port puerta_abierta, input, 1, meaning door open.
REQ-012 The block SHALL have port luces, output, NB, meaning button lamps.
REQ-013 The block SHALL have port display_num, output, WP, meaning floor shown.
REQ-014 The block SHALL have port display_dir, output, 2, meaning 00 idle, 10 up, 11 down, 01 door.
REQ-015 The block SHALL have port err_piso, output, 1, meaning piso out of range.

Function
REQ-016 All outputs SHALL be registered, with 1-cycle latency from input to output.
REQ-017 Each luces bit SHALL set on its solicitudes bit and clear on its atendidos bit; when both occur in the same cycle, set SHALL win.
REQ-018 display_num SHALL load piso when piso < PISOS; otherwise it SHALL hold its previous value and err_piso SHALL pulse high for that cycle only.
REQ-019 The direction FSM SHALL have states REPOSO, SUBE, BAJA and PUERTA, encoded on display_dir as 00, 10, 11 and 01.
REQ-020 FSM priority SHALL be, highest first: puerta_abierta -> PUERTA; subiendo and not bajando -> SUBE; bajando and not subiendo -> BAJA; subiendo and bajando together -> hold current state.
REQ-021 With none of those inputs asserted, the FSM SHALL hold SUBE/BAJA while any luces bit is set, else go to REPOSO.
REQ-022 In REPOSO with luces nonzero and no motion, display_dir SHALL show 01 to indicate pending requests.
REQ-023 The PUERTA -> REPOSO/SUBE/BAJA transition SHALL occur in the cycle after puerta_abierta falls, per REQ-020/REQ-021.

Reset
REQ-024 While rst_n=0 at a clk edge, the block SHALL force luces=0, display_num=0, display_dir=00, err_piso=0, FSM=REPOSO and blink counter=0.
REQ-025 Reset SHALL take priority over every concurrent solicitudes, atendidos or door event, including mid-blink.

Configuration
REQ-026 With macro INTERFAZ_PARPADEO_EN defined, the block SHALL include an 8-bit counter that runs only in PUERTA and toggles a phase bit every PARPADEO cycles.
REQ-027 With INTERFAZ_PARPADEO_EN defined, display_dir[0] SHALL equal the phase bit in PUERTA (display_dir[1]=0), and the counter and phase SHALL clear on PUERTA exit.
REQ-028 Without INTERFAZ_PARPADEO_EN, no counter SHALL be built and PUERTA SHALL show a steady 01.

Verification
REQ-029 Reset, then solicitudes=10'h004 for 1 cycle -> luces=10'h004 the next cycle and held; atendidos=10'h004 -> luces=0.
REQ-030 solicitudes=atendidos=10'h010 in the same cycle, luces=0 before -> luces=10'h010.
REQ-031 PISOS=5, WP=3, piso=3 then piso=6 -> display_num=3, and while piso=6: display_num holds 3, err_piso=1 for 1 cycle.
REQ-032 subiendo=1 -> display_dir=10; subiendo=0 with luces!=0 -> stays 10; luces cleared -> 00.
REQ-033 With INTERFAZ_PARPADEO_EN and PARPADEO=4, puerta_abierta=1 for 20 cycles -> display_dir alternates 00/01 every 4 cycles; drop door -> next cycle normal code.
REQ-034 rst_n=0 during PUERTA with luces=10'h3FF -> all outputs 0 on the next edge.
